// File: rtl/vec_collect.sv
// Serializes a valid/ready element stream into COLS-wide vectors, padding short ones with max positive.
// Latency: out_valid rises on the edge that accepts the completing element; len_err is registered the same way.
// Backpressure: a fill buffer plus output register absorb one stall; in_ready drops only while a full vector waits.
module vec_collect #(
    parameter int COLS  = 1,
    parameter int WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic signed [WIDTH-1:0]  in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     in_last,
    output logic [COLS:1][WIDTH-1:0] out_vec,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     len_err
);

    localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
    localparam logic [CW-1:0]    CNT_LAST = CW'(COLS - 1);
    localparam logic [WIDTH-1:0] PAD      = {1'b0, {(WIDTH-1){1'b1}}};

    typedef enum logic {FILL, WAIT} state_t;

    state_t                   state, state_nxt;
    logic [CW-1:0]            cnt, cnt_nxt;
    logic [COLS:1][WIDTH-1:0] fill, fill_nxt, out_vec_nxt;
    logic                     accept, at_end, complete, xfer, out_free, load;
    logic                     out_valid_nxt, len_err_nxt;

    assign in_ready = rst_n && (state == FILL);

    always_comb begin
        accept   = in_valid && in_ready;
        at_end   = (cnt == CNT_LAST);
        complete = accept && (at_end || in_last);
        xfer     = out_valid && out_ready;
        out_free = !out_valid || out_ready;

        // Write the accepted element; a short vector pads every slot beyond it.
        fill_nxt = fill;
        for (int i = 1; i <= COLS; i++) begin
            if (accept && (int'(cnt) + 1 == i))
                fill_nxt[i] = in_data;
            else if (accept && in_last && (int'(cnt) + 1 < i))
                fill_nxt[i] = PAD;
        end

        if (complete)
            cnt_nxt = '0;
        else if (accept)
            cnt_nxt = cnt + CW'(1);
        else
            cnt_nxt = cnt;

        state_nxt   = state;
        load        = 1'b0;
        out_vec_nxt = out_vec;
        if (state == FILL) begin
            if (complete && out_free) begin
                load        = 1'b1;
                out_vec_nxt = fill_nxt;
            end else if (complete) begin
                state_nxt = WAIT;
            end
        end else begin
            if (xfer) begin
                load        = 1'b1;
                out_vec_nxt = fill;
                state_nxt   = FILL;
            end
        end

        out_valid_nxt = load ? 1'b1 : (xfer ? 1'b0 : out_valid);
        // Error when the last flag and the full count disagree.
        len_err_nxt   = complete && (at_end != in_last);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= FILL;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            fill      <= '0;
            out_vec   <= '0;
            out_valid <= 1'b0;
            len_err   <= 1'b0;
        end else begin
            cnt       <= cnt_nxt;
            fill      <= fill_nxt;
            out_vec   <= out_vec_nxt;
            out_valid <= out_valid_nxt;
            len_err   <= len_err_nxt;
        end
    end

endmodule

// File: tb/tb_vec_collect.sv
// Directed bench for vec_collect (COLS=4, WIDTH=16): per-cycle vector table plus reset sequences.
module tb_vec_collect;

    logic              clk = 1'b0;
    logic              rst_n;
    logic signed [15:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic              in_last;
    logic [4:1][15:0]  out_vec;
    logic              out_valid;
    logic              out_ready;
    logic              len_err;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    vec_collect #(.COLS(4), .WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
        .out_vec(out_vec), .out_valid(out_valid), .out_ready(out_ready), .len_err(len_err)
    );

    typedef struct {
        logic        vld;
        logic [15:0] dat;
        logic        last;
        logic        ordy;
        logic        ov;
        logic        ir;
        logic        le;
        logic        chkv;
        logic [63:0] vec;
    } vec_t;

    vec_t tbl[$];

    function automatic logic [63:0] mk(input logic [15:0] a, b, c, d);
        return {d, c, b, a};
    endfunction

    task automatic add(input logic vld, input logic [15:0] dat, input logic last, input logic ordy,
                       input logic ov, input logic ir, input logic le, input logic chkv,
                       input logic [63:0] vec);
        vec_t r;
        r.vld = vld; r.dat = dat; r.last = last; r.ordy = ordy;
        r.ov = ov; r.ir = ir; r.le = le; r.chkv = chkv; r.vec = vec;
        tbl.push_back(r);
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic cyc(input logic vld, input logic [15:0] dat, input logic last, input logic ordy);
        in_valid  = vld;
        in_data   = dat;
        in_last   = last;
        out_ready = ordy;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b0;
        #1;
        chk("reset in_ready",  64'(in_ready),  64'd0);
        chk("reset out_valid", 64'(out_valid), 64'd0);
        chk("reset len_err",   64'(len_err),   64'd0);
        chk("reset out_vec",   64'(out_vec),   64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post-reset in_ready", 64'(in_ready), 64'd1);

        // basic vector, out_ready=1
        add(1, 16'd5,     0, 1, 0, 1, 0, 0, 0);
        add(1, 16'hFFFD,  0, 1, 0, 1, 0, 0, 0);
        add(1, 16'd7,     0, 1, 0, 1, 0, 0, 0);
        add(1, 16'd2,     1, 1, 1, 1, 0, 1, mk(16'd5, 16'hFFFD, 16'd7, 16'd2));
        add(0, 16'd0,     0, 1, 0, 1, 0, 0, 0);
        // back-to-back
        add(1, 16'd1, 0, 1, 0, 1, 0, 0, 0);
        add(1, 16'd2, 0, 1, 0, 1, 0, 0, 0);
        add(1, 16'd3, 0, 1, 0, 1, 0, 0, 0);
        add(1, 16'd4, 1, 1, 1, 1, 0, 1, mk(16'd1, 16'd2, 16'd3, 16'd4));
        add(1, 16'd5, 0, 1, 0, 1, 0, 0, 0);
        add(1, 16'd6, 0, 1, 0, 1, 0, 0, 0);
        add(1, 16'd7, 0, 1, 0, 1, 0, 0, 0);
        add(1, 16'd8, 1, 1, 1, 1, 0, 1, mk(16'd5, 16'd6, 16'd7, 16'd8));
        add(0, 16'd0, 0, 1, 0, 1, 0, 0, 0);
        // backpressure: second vector parks in the fill buffer
        add(1, 16'd1, 0, 0, 0, 1, 0, 0, 0);
        add(1, 16'd2, 0, 0, 0, 1, 0, 0, 0);
        add(1, 16'd3, 0, 0, 0, 1, 0, 0, 0);
        add(1, 16'd4, 1, 0, 1, 1, 0, 1, mk(16'd1, 16'd2, 16'd3, 16'd4));
        add(1, 16'd5, 0, 0, 1, 1, 0, 1, mk(16'd1, 16'd2, 16'd3, 16'd4));
        add(1, 16'd6, 0, 0, 1, 1, 0, 1, mk(16'd1, 16'd2, 16'd3, 16'd4));
        add(1, 16'd7, 0, 0, 1, 1, 0, 1, mk(16'd1, 16'd2, 16'd3, 16'd4));
        add(1, 16'd8, 1, 0, 1, 0, 0, 1, mk(16'd1, 16'd2, 16'd3, 16'd4));
        add(1, 16'd99, 0, 1, 1, 1, 0, 1, mk(16'd5, 16'd6, 16'd7, 16'd8));
        add(0, 16'd0, 0, 1, 0, 1, 0, 0, 0);
        // short vector
        add(1, 16'd1, 0, 1, 0, 1, 0, 0, 0);
        add(1, 16'd2, 1, 1, 1, 1, 1, 1, mk(16'd1, 16'd2, 16'h7FFF, 16'h7FFF));
        add(0, 16'd0, 0, 1, 0, 1, 0, 0, 0);
        // missing last, then 13 starts a new vector
        add(1, 16'd9,  0, 1, 0, 1, 0, 0, 0);
        add(1, 16'd10, 0, 1, 0, 1, 0, 0, 0);
        add(1, 16'd11, 0, 1, 0, 1, 0, 0, 0);
        add(1, 16'd12, 0, 1, 1, 1, 1, 1, mk(16'd9, 16'd10, 16'd11, 16'd12));
        add(1, 16'd13, 0, 1, 0, 1, 0, 0, 0);
        add(1, 16'd14, 0, 1, 0, 1, 0, 0, 0);
        add(1, 16'd15, 0, 1, 0, 1, 0, 0, 0);
        add(1, 16'd16, 1, 1, 1, 1, 0, 1, mk(16'd13, 16'd14, 16'd15, 16'd16));
        add(0, 16'd0,  0, 1, 0, 1, 0, 0, 0);

        foreach (tbl[i]) begin
            cyc(tbl[i].vld, tbl[i].dat, tbl[i].last, tbl[i].ordy);
            chk($sformatf("v%0d out_valid", i), 64'(out_valid), 64'(tbl[i].ov));
            chk($sformatf("v%0d in_ready", i),  64'(in_ready),  64'(tbl[i].ir));
            chk($sformatf("v%0d len_err", i),   64'(len_err),   64'(tbl[i].le));
            if (tbl[i].chkv)
                chk($sformatf("v%0d out_vec", i), 64'(out_vec), tbl[i].vec);
        end

        // reset while a short vector sits in WAIT with len_err high
        cyc(1, 16'd1, 0, 0);
        cyc(1, 16'd2, 0, 0);
        cyc(1, 16'd3, 0, 0);
        cyc(1, 16'd4, 1, 0);
        cyc(1, 16'd5, 0, 0);
        cyc(1, 16'd6, 1, 0);
        chk("wait in_ready", 64'(in_ready), 64'd0);
        chk("wait len_err",  64'(len_err),  64'd1);
        in_valid = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        chk("rstA out_valid", 64'(out_valid), 64'd0);
        chk("rstA in_ready",  64'(in_ready),  64'd0);
        chk("rstA len_err",   64'(len_err),   64'd0);
        chk("rstA out_vec",   64'(out_vec),   64'd0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        cyc(1, 16'd21, 0, 1);
        cyc(1, 16'd22, 0, 1);
        cyc(1, 16'd23, 0, 1);
        cyc(1, 16'd24, 1, 1);
        chk("rstA new out_valid", 64'(out_valid), 64'd1);
        chk("rstA new len_err",   64'(len_err),   64'd0);
        chk("rstA new out_vec",   64'(out_vec),   mk(16'd21, 16'd22, 16'd23, 16'd24));

        // reset after two accepts of a partial vector
        cyc(1, 16'd30, 0, 1);
        cyc(1, 16'd31, 0, 1);
        in_valid = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        chk("rstB in_ready",  64'(in_ready),  64'd0);
        chk("rstB out_valid", 64'(out_valid), 64'd0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        cyc(1, 16'd40, 0, 1);
        cyc(1, 16'd41, 0, 1);
        cyc(1, 16'd42, 0, 1);
        cyc(1, 16'd43, 1, 1);
        chk("rstB new out_valid", 64'(out_valid), 64'd1);
        chk("rstB new len_err",   64'(len_err),   64'd0);
        chk("rstB new out_vec",   64'(out_vec),   mk(16'd40, 16'd41, 16'd42, 16'd43));
        cyc(0, 16'd0, 0, 1);
        chk("rstB drain out_valid", 64'(out_valid), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/vec_collect.md
# vec_collect

Upstream serializer-to-vector stage for the vector reduction blocks (vecmin and friends). It accepts a stream of signed fixed-point elements over a valid/ready handshake and assembles them into a `COLS`-wide vector `out_vec[COLS:1]`. It presents each completed vector on a registered valid/ready output port, and keeps a fill buffer plus an output holding register so it can run back-to-back without bubbles. Short vectors are padded with the maximum positive value so that a downstream minimum is unaffected.

## Interface

**Parameters**
- `COLS`, default 1: number of elements per vector, at least 1.
- `g.WIDTH`: element width in bits, taken from the `fixedp` interface.

**Ports**
- `g.clk` input, 1 bit: the single clock, carried in the `fixedp g` interface.
- `g.reset_l` input, 1 bit: asynchronous, active-low reset, carried in the `fixedp g` interface.
- `in_data` input, `g.WIDTH` bits, signed: element to be stored.
- `in_valid` input, 1 bit: `in_data` is valid.
- `in_ready` output, 1 bit: block can accept an element.
- `in_last` input, 1 bit: the accepted element is the final one of its vector.
- `out_vec` output, `[COLS:1][g.WIDTH-1:0]`, signed: assembled vector; index 1 holds the first accepted element.
- `out_valid` output, 1 bit: `out_vec` holds an unconsumed vector.
- `out_ready` input, 1 bit: consumer takes `out_vec`.
- `len_err` output, 1 bit: one-cycle pulse indicating a vector-length mismatch.

## Operation

- **Handshakes.**
  - Input accept: `in_valid && in_ready` at a rising edge of `g.clk`.
  - Output transfer: `out_valid && out_ready` at a rising edge of `g.clk`.
- **Fill buffer.** Holds `fill[COLS:1]` plus an index counter `cnt` with range 0..COLS-1.
  - An accepted element is written to `fill[cnt+1]`.
  - `cnt` increments; it clears to 0 on completion.
- **Vector completion.** A vector completes on the accept where either:
  - `cnt == COLS-1`, or
  - `in_last == 1`.
- **Short vector** (`in_last` with `cnt < COLS-1`):
  - Positions `cnt+2..COLS` are filled with the pad value `{1'b0, {g.WIDTH-1{1'b1}}}`, the maximum positive value.
  - `len_err` pulses.
- **Missing last** (`cnt == COLS-1` with `in_last == 0`):
  - The vector completes normally.
  - `len_err` pulses.
  - The next accepted element starts a new vector at index 1.
- **State machine.**
  - `FILL`:
    - `in_ready = 1` while `g.reset_l` is high.
    - On completion, if the output register is free, the completed vector goes straight to the output register and the state stays `FILL`.
    - The output register counts as free when `out_valid == 0`, or when an output transfer happens on the same edge.
    - Otherwise the state goes to `WAIT`.
  - `WAIT`:
    - `in_ready = 0`.
    - On an output transfer, `fill` is copied to `out_vec`, `out_valid` stays 1, and the state returns to `FILL`.
- **Output register.**
  - `out_valid` sets on a load and clears on a transfer with no same-edge load.
  - `out_vec` is stable while `out_valid && !out_ready`.
- **Simultaneous events.**
  - Completion and output transfer on the same edge: the new vector is loaded and `out_valid` stays 1 with no bubble.
  - `in_last` with `COLS == 1`: a normal completion, no `len_err`.
- **Width rule.** Elements are stored verbatim: no arithmetic, saturation or sign change.
- **Reset** (asynchronous, while `g.reset_l == 0`):
  - State `FILL`, `cnt = 0`, all `fill` entries 0.
  - `out_vec = 0`, `out_valid = 0`, `len_err = 0`, `in_ready = 0`.
  - A partial or pending vector is discarded.

## Timing

- Latency: `out_valid` rises on the clock edge that accepts the completing element, so it is visible in the following cycle.
- Throughput: with `out_ready` held at 1, one vector every `COLS` accepted elements. `COLS == 1` gives one vector per cycle.
- `in_ready` is combinational from state and reset only. It does not depend on `in_valid` or `out_ready`.
- Backpressure release: `in_ready` returns to 1 in the cycle after the `WAIT`-state output transfer.
- `len_err` is registered. It is high for exactly one cycle, the cycle after the completing accept, regardless of `out_ready`.

## Test plan

1. **Basic vector.** `COLS=4`, `WIDTH=16`, `out_ready=1`. Stream 5, -3, 7, 2 on consecutive cycles with `in_last` on 2.
   - Expect `out_vec[1..4] = 5, -3, 7, 2`.
   - Expect `out_valid` high for exactly 1 cycle, the cycle after the 4th accept.
   - Expect `len_err = 0`.
2. **Back-to-back.** Stream 8 elements continuously (1..8, `in_last` on 4 and 8), `out_ready=1`.
   - Expect `out_valid` high in cycles 5 and 9 with vectors {1,2,3,4} and {5,6,7,8}.
   - Expect `in_ready` never low.
3. **Backpressure.** Same stream as scenario 2 with `out_ready=0`.
   - Expect `in_ready` to fall after the 8th accept, with `out_vec = {1,2,3,4}` held.
   - Raise `out_ready` for one cycle: `out_vec` becomes {5,6,7,8} on the next edge, and `in_ready = 1` the following cycle.
4. **Short vector.** Stream 1, 2 with `in_last` on 2.
   - Expect `out_vec = 1, 2, 0x7FFF, 0x7FFF`.
   - Expect a 1-cycle `len_err` pulse.
5. **Missing last.** Stream 4 elements, 9..12, with `in_last=0`, followed by 13.
   - Expect vector {9,10,11,12} with a `len_err` pulse.
   - Expect 13 lands at index 1 of the next vector.
6. **Reset mid-fill.** Assert `g.reset_l=0` asynchronously after 2 accepts, with a vector pending in `WAIT`.
   - Expect `out_valid`, `in_ready` and `len_err` at 0 immediately.
   - After release, stream 4 elements: they form a clean vector starting at index 1.
